// File: rtl/mac_sched.sv
// mac_sched: tile sequencer for the 8x6 systolic MAC array.
// Buffers one weight set, replays it row by row under the array's w_en skew,
// streams cfg_len framed activation vectors, waits for the result to drain,
// then pulses done.
// Optional build macro: MAC_SCHED_PERF_EN adds perf_busy_cyc / perf_stall_cyc.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; cfg_* latched on start
// S_LOAD_W  | accepting ROW weight beats into the buffer
// S_ISSUE_W | replaying buffer[k] onto w, one row per cycle, no stalls
// S_GAP     | one settle cycle, w held at last row, w_en low
// S_STREAM  | activation pass-through with first/last framing
// S_DRAIN   | waiting for the array's output last
// S_DONE    | one-cycle done pulse
module mac_sched #(
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int CW     = 19,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int LW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LW-1:0]            cfg_len,
    input  logic [COLUMN-1:0]        cfg_col_en,
    input  logic [CW-1:0]            cfg_bias,
    output logic                     busy,
    output logic                     done,
    input  logic [COLUMN*WW-1:0]     wt_s_data,
    input  logic                     wt_s_valid,
    output logic                     wt_s_ready,
    input  logic [ROW*DW-1:0]        act_s_data,
    input  logic                     act_s_valid,
    output logic                     act_s_ready,
    output logic [COLUMN*WW-1:0]     w,
    output logic [COLUMN-1:0]        w_en,
    output logic [COLUMN*CW-1:0]     ci,
    output logic [ROW*DW-1:0]        mac_m_data,
    output logic                     mac_m_first,
    output logic                     mac_m_last,
    output logic                     mac_m_valid,
    input  logic                     mac_m_ready,
    input  logic                     mac_s_valid,
    input  logic                     mac_s_last
`ifdef MAC_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_busy_cyc,
    output logic [31:0]              perf_stall_cyc
`endif
);

    localparam int KW = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_ISSUE_W = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]              r_state;
    logic [KW-1:0]           r_k;
    logic [LW-1:0]           r_n;
    logic [LW-1:0]           r_len;
    logic [COLUMN-1:0]       r_col_en;
    logic [COLUMN*WW-1:0]    r_buf [ROW];
    logic [COLUMN*WW-1:0]    r_w;
    logic [COLUMN-1:0]       r_w_en;
    logic [COLUMN*CW-1:0]    r_ci;

    logic w_start_acc;
    logic w_wt_hs;
    logic w_act_hs;
    logic w_k_last;
    logic w_last_beat;
    logic w_stream;

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_wt_hs     = wt_s_valid && (r_state == S_LOAD_W);
    assign w_stream    = (r_state == S_STREAM);
    assign w_act_hs    = w_stream && act_s_valid && mac_m_ready;
    assign w_k_last    = (r_k == KW'(ROW - 1));
    assign w_last_beat = (r_n == (r_len - LW'(1)));

    // Tile sequencing: state, row index k and beat counter n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_n      <= '0;
            r_len    <= '0;
            r_col_en <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len    <= cfg_len;
                        r_col_en <= cfg_col_en;
                        r_k      <= '0;
                        r_state  <= (cfg_len == '0) ? S_DONE : S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_wt_hs) begin
                        if (w_k_last) begin
                            r_k     <= '0;
                            r_state <= S_ISSUE_W;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_ISSUE_W: begin
                    if (w_k_last) begin
                        r_k     <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_GAP: begin
                    r_n     <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_act_hs) begin
                        r_n <= r_n + LW'(1);
                        if (w_last_beat) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mac_s_valid && mac_s_last) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Weight buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wt_hs) r_buf[r_k] <= wt_s_data;
    end

    // Registered weight bus: preload row 0 as the load finishes so each
    // ISSUE_W cycle k presents buffer[k]; w holds the last row through GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_w_en <= '0;
        end else begin
            r_w_en <= '0;
            if (w_wt_hs && w_k_last) begin
                r_w    <= (r_k == '0) ? wt_s_data : r_buf[0];
                r_w_en <= r_col_en;
            end else if ((r_state == S_ISSUE_W) && !w_k_last) begin
                r_w <= r_buf[r_k + KW'(1)];
            end
        end
    end

    // Bias replicated across all columns from accepted start until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ci <= '0;
        end else if (w_start_acc) begin
            r_ci <= {COLUMN{cfg_bias}};
        end else if (r_state == S_DONE) begin
            r_ci <= '0;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign wt_s_ready  = (r_state == S_LOAD_W);
    assign act_s_ready = w_stream && mac_m_ready;
    assign mac_m_valid = w_stream && act_s_valid;
    assign mac_m_data  = w_stream ? act_s_data : '0;
    assign mac_m_first = mac_m_valid && (r_n == '0);
    assign mac_m_last  = mac_m_valid && w_last_beat;
    assign w           = r_w;
    assign w_en        = r_w_en;
    assign ci          = r_ci;

`ifdef MAC_SCHED_PERF_EN
    // Saturating busy / stream-stall counters, cleared on accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (w_start_acc) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != 32'hFFFF_FFFF))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (w_stream && act_s_valid && !mac_m_ready && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule
